// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline hazard controller: FSM states, forwarding selects
// and the register-match helper used by the hazard/forwarding compare unit.
package mips_pipe_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // A producer only matters when it really writes and its destination is not $0.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                       input logic wr);
        return wr && (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Status/control bundle between the pipeline stage registers (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             ex_RegWr;
    logic             ex_MemToReg;
    logic [4:0]       ex_wreg;
    logic             mem_RegWr;
    logic [4:0]       mem_wreg;
    logic             branch_taken;
    logic             dm_req;
    logic             dm_ack;
    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_flush;
    logic             front_hold;
    logic             memwb_stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             dm_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_RegWr, ex_MemToReg, ex_wreg,
               mem_RegWr, mem_wreg, branch_taken, dm_req, dm_ack,
        input  pc_hold, ifid_hold, ifid_flush, idex_flush, front_hold, memwb_stall,
               fwd_a, fwd_b, dm_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_RegWr, ex_MemToReg, ex_wreg,
               mem_RegWr, mem_wreg, branch_taken, dm_req, dm_ack,
        output pc_hold, ifid_hold, ifid_flush, idex_flush, front_hold, memwb_stall,
               fwd_a, fwd_b, dm_err, stall_cnt
    );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational rs/rt compare against EX and MEM destinations: forwarding selects and raw-hazard flag.
// FORWARD_EN defined: forward from EX/MEM or MEM/WB, only load-use is a hazard; otherwise every match stalls.
module hazard_fwd_unit
    import mips_pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_RegWr,
    input  logic       ex_MemToReg,
    input  logic [4:0] ex_wreg,
    input  logic       mem_RegWr,
    input  logic [4:0] mem_wreg,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       raw_hazard
);

    logic ex_rs, ex_rt, mem_rs, mem_rt, load_use;

    assign ex_rs    = reg_match(id_rs, ex_wreg, ex_RegWr);
    assign ex_rt    = reg_match(id_rt, ex_wreg, ex_RegWr);
    assign mem_rs   = reg_match(id_rs, mem_wreg, mem_RegWr);
    assign mem_rt   = reg_match(id_rt, mem_wreg, mem_RegWr);
    assign load_use = ex_MemToReg && ((ex_rs && id_use_rs) || (ex_rt && id_use_rt));

`ifdef FORWARD_EN
    // The youngest producer (EX) wins when both stages write the same register.
    assign fwd_a      = ex_rs ? FWD_EXMEM : (mem_rs ? FWD_MEMWB : FWD_REG);
    assign fwd_b      = ex_rt ? FWD_EXMEM : (mem_rt ? FWD_MEMWB : FWD_REG);
    assign raw_hazard = load_use;
`else
    assign fwd_a      = FWD_REG;
    assign fwd_b      = FWD_REG;
    assign raw_hazard = load_use
                      || (id_use_rs && (ex_rs || mem_rs))
                      || (id_use_rt && (ex_rt || mem_rt));
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: data-memory wait FSM, branch flush,
// load-use/RAW stalls and stall counter. Forwarding behaviour selected by FORWARD_EN in hazard_fwd_unit.
module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int DM_TIMEOUT = 16,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam bit TIMEOUT_ON = (DM_TIMEOUT > 0);
    localparam int WC_W       = (DM_TIMEOUT > 1) ? $clog2(DM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_ON ? DM_TIMEOUT - 1 : 0);

    logic [0:0]       state, state_nx;
    logic [WC_W-1:0]  wait_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             dm_err;
    logic             in_wait, enter_wait, mem_hold, timeout_hit;
    logic             raw_hazard;
    logic [1:0]       fwd_a_raw, fwd_b_raw;
    logic             pc_hold, ifid_hold, ifid_flush, idex_flush, front_hold, memwb_stall;
    logic [1:0]       fwd_a, fwd_b;

    hazard_fwd_unit u_hfu (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_use_rs   (bus.id_use_rs),
        .id_use_rt   (bus.id_use_rt),
        .ex_RegWr    (bus.ex_RegWr),
        .ex_MemToReg (bus.ex_MemToReg),
        .ex_wreg     (bus.ex_wreg),
        .mem_RegWr   (bus.mem_RegWr),
        .mem_wreg    (bus.mem_wreg),
        .fwd_a       (fwd_a_raw),
        .fwd_b       (fwd_b_raw),
        .raw_hazard  (raw_hazard)
    );

    // The request cycle itself already stalls, so the MEM stage never advances on a miss.
    always_comb begin
        in_wait     = (state == ST_MEM_WAIT);
        enter_wait  = !in_wait && bus.dm_req && !bus.dm_ack;
        mem_hold    = enter_wait || (in_wait && !bus.dm_ack);
        timeout_hit = TIMEOUT_ON && in_wait && !bus.dm_ack && (wait_cnt == WC_LAST);
        state_nx    = state;
        if (enter_wait)
            state_nx = ST_MEM_WAIT;
        else if (in_wait && (bus.dm_ack || timeout_hit))
            state_nx = ST_RUN;
    end

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        front_hold  = 1'b0;
        memwb_stall = 1'b0;
        fwd_a       = FWD_REG;
        fwd_b       = FWD_REG;
        if (!rst) begin
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
            if (mem_hold) begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                front_hold  = 1'b1;
                memwb_stall = 1'b1;
            end else if (bus.branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (raw_hazard) begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            dm_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            if (enter_wait)
                wait_cnt <= '0;
            else if (in_wait && TIMEOUT_ON)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                dm_err <= 1'b1;
            if (pc_hold && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.pc_hold     = pc_hold;
    assign bus.ifid_hold   = ifid_hold;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.front_hold  = front_hold;
    assign bus.memwb_stall = memwb_stall;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.dm_err      = dm_err;
    assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations adapt to the FORWARD_EN build option.
module tb_pipe_hazard_ctrl;

`ifdef FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    localparam logic [5:0] CTL_NONE = 6'b000000;
    localparam logic [5:0] CTL_LU   = 6'b110100;
    localparam logic [5:0] CTL_BR   = 6'b001100;
    localparam logic [5:0] CTL_MEM  = 6'b110011;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipe_hazard_ctrl #(.DM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {pc_hold, ifid_hold, ifid_flush, idex_flush, front_hold, memwb_stall}
    function automatic logic [5:0] ctl();
        return {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_flush,
                bus.front_hold, bus.memwb_stall};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs = 5'd0;  bus.id_rt = 5'd0;  bus.id_use_rs = 1'b0;  bus.id_use_rt = 1'b0;
        bus.ex_RegWr = 1'b0;  bus.ex_MemToReg = 1'b0;  bus.ex_wreg = 5'd0;
        bus.mem_RegWr = 1'b0;  bus.mem_wreg = 5'd0;
        bus.branch_taken = 1'b0;  bus.dm_req = 1'b0;  bus.dm_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.dm_req = 1'b1;
        bus.ex_RegWr = 1'b1;  bus.ex_wreg = 5'd7;  bus.id_rs = 5'd7;  bus.id_use_rs = 1'b1;
        rst = 1'b1;
        cyc();
        #3;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL rst_ctl got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        checks++;
        if (bus.fwd_a !== 2'd0) $display("FAIL rst_fwd_a got=%0d exp=0", bus.fwd_a); else passed++;
        checks++;
        if (bus.stall_cnt !== 16'd0) $display("FAIL rst_cnt got=%0d exp=0", bus.stall_cnt); else passed++;
        checks++;
        if (bus.dm_err !== 1'b0) $display("FAIL rst_dm_err got=%b exp=0", bus.dm_err); else passed++;
        clear_inputs();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_RegWr = 1'b1;  bus.ex_MemToReg = 1'b1;  bus.ex_wreg = 5'd2;
        bus.id_rs = 5'd2;  bus.id_use_rs = 1'b1;  bus.id_rt = 5'd5;  bus.id_use_rt = 1'b1;
        #3;
        checks++;
        if (ctl() !== CTL_LU) $display("FAIL lu_stall got=%b exp=%b", ctl(), CTL_LU); else passed++;
        cyc();
        checks++;
        if (bus.stall_cnt !== 16'd1) $display("FAIL lu_cnt1 got=%0d exp=1", bus.stall_cnt); else passed++;
        bus.ex_RegWr = 1'b0;  bus.ex_MemToReg = 1'b0;  bus.ex_wreg = 5'd0;
        bus.mem_RegWr = 1'b1;  bus.mem_wreg = 5'd2;
        #3;
        checks++;
        if (ctl() !== (FWD_ON ? CTL_NONE : CTL_LU))
            $display("FAIL lu_after got=%b exp=%b", ctl(), FWD_ON ? CTL_NONE : CTL_LU); else passed++;
        checks++;
        if (bus.fwd_a !== (FWD_ON ? 2'd2 : 2'd0))
            $display("FAIL lu_fwd_a got=%0d exp=%0d", bus.fwd_a, FWD_ON ? 2 : 0); else passed++;
        cyc();
        bus.mem_RegWr = 1'b0;  bus.mem_wreg = 5'd0;
        #3;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL lu_clear got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        checks++;
        if (bus.stall_cnt !== (FWD_ON ? 16'd1 : 16'd2))
            $display("FAIL lu_cnt got=%0d exp=%0d", bus.stall_cnt, FWD_ON ? 1 : 2); else passed++;
    endtask

    task automatic test_forward();
        do_reset();
        bus.ex_RegWr = 1'b1;  bus.ex_wreg = 5'd3;
        bus.id_rs = 5'd1;  bus.id_use_rs = 1'b1;  bus.id_rt = 5'd3;  bus.id_use_rt = 1'b1;
        #3;
        checks++;
        if (bus.fwd_b !== (FWD_ON ? 2'd1 : 2'd0))
            $display("FAIL fw_ex_b got=%0d exp=%0d", bus.fwd_b, FWD_ON ? 1 : 0); else passed++;
        checks++;
        if (bus.fwd_a !== 2'd0) $display("FAIL fw_ex_a got=%0d exp=0", bus.fwd_a); else passed++;
        checks++;
        if (ctl() !== (FWD_ON ? CTL_NONE : CTL_LU))
            $display("FAIL fw_ex_ctl got=%b exp=%b", ctl(), FWD_ON ? CTL_NONE : CTL_LU); else passed++;
        bus.mem_RegWr = 1'b1;  bus.mem_wreg = 5'd3;
        #2;
        checks++;
        if (bus.fwd_b !== (FWD_ON ? 2'd1 : 2'd0))
            $display("FAIL fw_prio got=%0d exp=%0d", bus.fwd_b, FWD_ON ? 1 : 0); else passed++;
        cyc();
        bus.ex_RegWr = 1'b0;  bus.ex_wreg = 5'd0;
        #3;
        checks++;
        if (bus.fwd_b !== (FWD_ON ? 2'd2 : 2'd0))
            $display("FAIL fw_mem_b got=%0d exp=%0d", bus.fwd_b, FWD_ON ? 2 : 0); else passed++;
        checks++;
        if (ctl() !== (FWD_ON ? CTL_NONE : CTL_LU))
            $display("FAIL fw_mem_ctl got=%b exp=%b", ctl(), FWD_ON ? CTL_NONE : CTL_LU); else passed++;
        cyc();
        bus.mem_RegWr = 1'b0;  bus.mem_wreg = 5'd0;
        #3;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL fw_clear got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        checks++;
        if (bus.stall_cnt !== (FWD_ON ? 16'd0 : 16'd2))
            $display("FAIL fw_cnt got=%0d exp=%0d", bus.stall_cnt, FWD_ON ? 0 : 2); else passed++;
    endtask

    task automatic test_zero_reg();
        do_reset();
        bus.ex_RegWr = 1'b1;  bus.ex_MemToReg = 1'b1;  bus.ex_wreg = 5'd0;
        bus.mem_RegWr = 1'b1;  bus.mem_wreg = 5'd0;
        bus.id_rs = 5'd0;  bus.id_use_rs = 1'b1;  bus.id_rt = 5'd0;  bus.id_use_rt = 1'b1;
        #3;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL zero_ctl got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        checks++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'd0)
            $display("FAIL zero_fwd got=%b exp=0000", {bus.fwd_a, bus.fwd_b}); else passed++;
        cyc();
        bus.ex_wreg = 5'd4;  bus.mem_RegWr = 1'b0;  bus.mem_wreg = 5'd0;
        bus.id_rs = 5'd4;  bus.id_use_rs = 1'b0;  bus.id_rt = 5'd9;
        #3;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL nouse_ctl got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        cyc();
        checks++;
        if (bus.stall_cnt !== 16'd0) $display("FAIL zero_cnt got=%0d exp=0", bus.stall_cnt); else passed++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.dm_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            checks++;
            if (ctl() !== CTL_MEM) $display("FAIL mw_hold%0d got=%b exp=%b", i, ctl(), CTL_MEM); else passed++;
            cyc();
        end
        bus.dm_ack = 1'b1;
        #3;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL mw_ack got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        cyc();
        bus.dm_req = 1'b0;  bus.dm_ack = 1'b0;
        #3;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL mw_run got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        checks++;
        if (bus.stall_cnt !== 16'd4) $display("FAIL mw_cnt got=%0d exp=4", bus.stall_cnt); else passed++;
        checks++;
        if (bus.dm_err !== 1'b0) $display("FAIL mw_err got=%b exp=0", bus.dm_err); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        bus.dm_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #3;
            checks++;
            if (ctl() !== CTL_MEM || bus.dm_err !== 1'b0)
                $display("FAIL to_wait%0d got=%b/%b exp=%b/0", i, ctl(), bus.dm_err, CTL_MEM); else passed++;
            cyc();
        end
        bus.dm_req = 1'b0;
        #3;
        checks++;
        if (bus.dm_err !== 1'b1) $display("FAIL to_err got=%b exp=1", bus.dm_err); else passed++;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL to_run got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        checks++;
        if (bus.stall_cnt !== 16'd17) $display("FAIL to_cnt got=%0d exp=17", bus.stall_cnt); else passed++;
        cyc();
        bus.dm_req = 1'b1;  bus.dm_ack = 1'b1;
        #3;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL to_fast got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        cyc();
        checks++;
        if (bus.dm_err !== 1'b1) $display("FAIL to_sticky got=%b exp=1", bus.dm_err); else passed++;
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        bus.branch_taken = 1'b1;
        bus.ex_RegWr = 1'b1;  bus.ex_MemToReg = 1'b1;  bus.ex_wreg = 5'd6;
        bus.id_rs = 5'd6;  bus.id_use_rs = 1'b1;
        #3;
        checks++;
        if (ctl() !== CTL_BR) $display("FAIL br_lu got=%b exp=%b", ctl(), CTL_BR); else passed++;
        cyc();
        clear_inputs();
        bus.dm_req = 1'b1;
        cyc();
        bus.branch_taken = 1'b1;
        #3;
        checks++;
        if (ctl() !== CTL_MEM) $display("FAIL br_wait got=%b exp=%b", ctl(), CTL_MEM); else passed++;
        cyc();
        bus.dm_ack = 1'b1;
        #3;
        checks++;
        if (ctl() !== CTL_BR) $display("FAIL br_ack got=%b exp=%b", ctl(), CTL_BR); else passed++;
        cyc();
        clear_inputs();
        #3;
        checks++;
        if (bus.stall_cnt !== 16'd2) $display("FAIL br_cnt got=%0d exp=2", bus.stall_cnt); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.dm_req = 1'b1;
        cyc();
        cyc();
        cyc();
        #3;
        checks++;
        if (bus.stall_cnt !== 16'd3) $display("FAIL rmw_pre got=%0d exp=3", bus.stall_cnt); else passed++;
        bus.ex_RegWr = 1'b1;  bus.ex_wreg = 5'd3;  bus.id_rs = 5'd3;  bus.id_use_rs = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL rmw_ctl got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        checks++;
        if (bus.fwd_a !== 2'd0) $display("FAIL rmw_fwd got=%0d exp=0", bus.fwd_a); else passed++;
        checks++;
        if (bus.stall_cnt !== 16'd0) $display("FAIL rmw_cnt got=%0d exp=0", bus.stall_cnt); else passed++;
        cyc();
        clear_inputs();
        rst = 1'b0;
        #3;
        checks++;
        if (ctl() !== CTL_NONE) $display("FAIL rmw_run got=%b exp=%b", ctl(), CTL_NONE); else passed++;
        cyc();
        checks++;
        if (bus.stall_cnt !== 16'd0) $display("FAIL rmw_cnt2 got=%0d exp=0", bus.stall_cnt); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_zero_reg();
        test_mem_wait();
        test_timeout();
        test_branch();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
